// File: rtl/local_port_ni.sv
// Local-port network interface: injection FIFO plus one-entry launch register toward the router,
// and a first-word-fall-through ejection FIFO with almost-full backpressure, overflow flag and flit counters.
module local_port_ni #(
  parameter int DATA_W       = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  parameter int INJ_DEPTH    = 4,
  parameter int EJ_DEPTH     = 8,
  parameter int OFF_SLACK    = 2,
  parameter int CNT_W        = 16,
  localparam int DIM0_W      = $clog2(NODE_PER_ROW),
  localparam int DIM1_W      = $clog2(NODE_PER_COL),
  localparam int DEST_W      = DIM0_W + DIM1_W,
  localparam int PAY_W       = DATA_W - DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inj_valid_i,
  input  logic [DEST_W-1:0] inj_dest_i,
  input  logic [PAY_W-1:0]  inj_payload_i,
  output logic              inj_ready_o,
  output logic              rtr_valid_o,
  output logic [DATA_W-1:0] rtr_data_o,
  input  logic              rtr_off_i,
  input  logic              rtr_valid_i,
  input  logic [DATA_W-1:0] rtr_data_i,
  output logic              rtr_off_o,
  output logic              ej_valid_o,
  output logic [DATA_W-1:0] ej_data_o,
  input  logic              ej_ready_i,
  output logic [CNT_W-1:0]  inj_cnt_o,
  output logic [CNT_W-1:0]  ej_cnt_o,
  output logic              ovf_o
);

  localparam int IA = $clog2(INJ_DEPTH);
  localparam int EA = $clog2(EJ_DEPTH);
  localparam logic [EA:0] EJ_OFF_TH = (EA+1)'(EJ_DEPTH - OFF_SLACK);

  logic [DATA_W-1:0] inj_mem_q [INJ_DEPTH];
  logic [IA:0]       inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
  logic              rtr_valid_q, rtr_valid_d;
  logic [DATA_W-1:0] rtr_data_q, rtr_data_d;
  logic [CNT_W-1:0]  inj_cnt_q, inj_cnt_d;
  logic              inj_full_s, inj_empty_s, inj_ready_s, inj_push_s, inj_pop_s;

  logic [DATA_W-1:0] ej_mem_q [EJ_DEPTH];
  logic [EA:0]       ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d;
  logic [EA:0]       ej_occ_s, ej_occ_next_s;
  logic [CNT_W-1:0]  ej_cnt_q, ej_cnt_d;
  logic              ovf_q, ovf_d, rtr_off_q, rtr_off_d;
  logic              ej_full_s, ej_empty_s, ej_push_s, ej_pop_s;

  // Injection side: ready comes only from registered pointers, never from a same-cycle launch.
  always_comb begin
    inj_full_s  = (inj_wr_q[IA] != inj_rd_q[IA]) && (inj_wr_q[IA-1:0] == inj_rd_q[IA-1:0]);
    inj_empty_s = (inj_wr_q == inj_rd_q);
    inj_ready_s = !rst && !inj_full_s;
    inj_push_s  = inj_valid_i && inj_ready_s;
    inj_pop_s   = !inj_empty_s && !rtr_off_i;
    inj_wr_d    = inj_wr_q;
    inj_rd_d    = inj_rd_q;
    rtr_valid_d = 1'b0;
    rtr_data_d  = rtr_data_q;
    inj_cnt_d   = inj_cnt_q;
    if (inj_push_s) begin
      inj_wr_d = inj_wr_q + (IA+1)'(1);
    end else begin
      inj_wr_d = inj_wr_q;
    end
    if (inj_pop_s) begin
      inj_rd_d    = inj_rd_q + (IA+1)'(1);
      rtr_valid_d = 1'b1;
      rtr_data_d  = inj_mem_q[inj_rd_q[IA-1:0]];
      inj_cnt_d   = inj_cnt_q + CNT_W'(1);
    end else begin
      rtr_valid_d = 1'b0;
    end
  end

  // Ejection side: a write into a full FIFO is still accepted when the head leaves in the same cycle.
  always_comb begin
    ej_full_s  = (ej_wr_q[EA] != ej_rd_q[EA]) && (ej_wr_q[EA-1:0] == ej_rd_q[EA-1:0]);
    ej_empty_s = (ej_wr_q == ej_rd_q);
    ej_pop_s   = !ej_empty_s && ej_ready_i;
    ej_push_s  = rtr_valid_i && (!ej_full_s || ej_pop_s);
    ej_occ_s   = ej_wr_q - ej_rd_q;
    ej_wr_d    = ej_wr_q;
    ej_rd_d    = ej_rd_q;
    ej_cnt_d   = ej_cnt_q;
    ovf_d      = ovf_q;
    if (ej_push_s) begin
      ej_wr_d  = ej_wr_q + (EA+1)'(1);
      ej_cnt_d = ej_cnt_q + CNT_W'(1);
    end else if (rtr_valid_i) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (ej_pop_s) begin
      ej_rd_d = ej_rd_q + (EA+1)'(1);
    end else begin
      ej_rd_d = ej_rd_q;
    end
    if (ej_push_s && !ej_pop_s) begin
      ej_occ_next_s = ej_occ_s + (EA+1)'(1);
    end else if (ej_pop_s && !ej_push_s) begin
      ej_occ_next_s = ej_occ_s - (EA+1)'(1);
    end else begin
      ej_occ_next_s = ej_occ_s;
    end
    rtr_off_d = (ej_occ_next_s >= EJ_OFF_TH);
  end

  // Control state; reset drops every buffered flit by collapsing the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_wr_q    <= '0;
      inj_rd_q    <= '0;
      rtr_valid_q <= 1'b0;
      rtr_data_q  <= '0;
      inj_cnt_q   <= '0;
      ej_wr_q     <= '0;
      ej_rd_q     <= '0;
      ej_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      rtr_off_q   <= 1'b0;
    end else begin
      inj_wr_q    <= inj_wr_d;
      inj_rd_q    <= inj_rd_d;
      rtr_valid_q <= rtr_valid_d;
      rtr_data_q  <= rtr_data_d;
      inj_cnt_q   <= inj_cnt_d;
      ej_wr_q     <= ej_wr_d;
      ej_rd_q     <= ej_rd_d;
      ej_cnt_q    <= ej_cnt_d;
      ovf_q       <= ovf_d;
      rtr_off_q   <= rtr_off_d;
    end
  end

  // FIFO storage arrays; contents are meaningless outside the pointer window.
  always_ff @(posedge clk) begin
    if (inj_push_s) begin
      inj_mem_q[inj_wr_q[IA-1:0]] <= {inj_dest_i, inj_payload_i};
    end
    if (ej_push_s) begin
      ej_mem_q[ej_wr_q[EA-1:0]] <= rtr_data_i;
    end
  end

  assign inj_ready_o = inj_ready_s;
  assign rtr_valid_o = rtr_valid_q;
  assign rtr_data_o  = rtr_data_q;
  assign rtr_off_o   = rtr_off_q;
  assign ej_valid_o  = !ej_empty_s;
  assign ej_data_o   = ej_empty_s ? '0 : ej_mem_q[ej_rd_q[EA-1:0]];
  assign inj_cnt_o   = inj_cnt_q;
  assign ej_cnt_o    = ej_cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/local_port_ni.md
# local_port_ni

Network interface for one flattened-butterfly node's local port (port 0). On the injection side it accepts `{destination, payload}` packets from the attached core, buffers them, and drives the router's local `valid_i`/`data_i` lane under the router's `off_sigs_o` backpressure. On the ejection side it absorbs flits from the router's local `valid_o`/`data_o` lane into a FIFO and drives the router's local `off_sigs_i`. It also presents ejected flits to the core through a valid/ready handshake and keeps flit counters.

## Interface
- `DATA_W`, 8, flit width; must be greater than `DIM0_W + DIM1_W`.
- `NODE_PER_ROW`, 4, nodes in dim0; `DIM0_W = $clog2(NODE_PER_ROW)`.
- `NODE_PER_COL`, 4, nodes in dim1; `DIM1_W = $clog2(NODE_PER_COL)`.
- `INJ_DEPTH`, 4, injection FIFO entries; power of 2.
- `EJ_DEPTH`, 8, ejection FIFO entries; power of 2, at least 4.
- `OFF_SLACK`, 2, free entries remaining when `rtr_off_o` asserts.
- `CNT_W`, 16, statistics counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inj_valid_i`  in  1  core offers a packet.
- `inj_dest_i`  in  `DIM0_W+DIM1_W`  destination as `{dim0, dim1}`, dim0 in the MSBs.
- `inj_payload_i`  in  `DATA_W-DIM0_W-DIM1_W`  payload.
- `inj_ready_o`  out  1  injection FIFO can accept a packet.
- `rtr_valid_o`  out  1  flit to the router's local input.
- `rtr_data_o`  out  `DATA_W`  flit as `{dest, payload}`; dest occupies the leading (most significant) bits.
- `rtr_off_i`  in  1  router local input FIFO almost full.
- `rtr_valid_i`  in  1  flit from the router's local output.
- `rtr_data_i`  in  `DATA_W`  ejected flit.
- `rtr_off_o`  out  1  ejection FIFO almost full; stop granting.
- `ej_valid_o`  out  1  ejection FIFO head valid.
- `ej_data_o`  out  `DATA_W`  ejection head flit (full flit, dest field not stripped).
- `ej_ready_i`  in  1  core consumes the head.
- `inj_cnt_o`  out  `CNT_W`  flits sent to the router, wrapping.
- `ej_cnt_o`  out  `CNT_W`  flits accepted from the router, wrapping.
- `ovf_o`  out  1  sticky: a flit arrived while the ejection FIFO was full.

## Operation
- **Injection push:** in a cycle where `inj_valid_i && inj_ready_o`, write `{inj_dest_i, inj_payload_i}` to the injection FIFO.
  - `inj_ready_o = !inj_full`, taken from registered state only; it does not anticipate a same-cycle pop.
- **Injection launch:** a one-entry output register holds `rtr_valid_o`/`rtr_data_o`.
  - Each cycle: if the FIFO is non-empty and `rtr_off_i == 0`, pop the head into the register and set `rtr_valid_o = 1` for the next cycle.
  - Otherwise `rtr_valid_o = 0` for the next cycle and `rtr_data_o` holds its value.
  - At most one flit per cycle.
  - `inj_cnt_o` increments on each launch.
- **Router contract:** `rtr_off_i` asserts with at least one free entry remaining, so a flit launched in the cycle `rtr_off_i` rises is never lost.
- **Ejection:** when `rtr_valid_i` is high, write `rtr_data_i` to the ejection FIFO unless it is full and no pop occurs in the same cycle.
  - An accepted write increments `ej_cnt_o`.
  - A rejected write is dropped and sets `ovf_o`, which stays set until `rst`.
  - Push while full with a simultaneous pop is accepted.
- **Ejection read:** first-word fall-through. `ej_valid_o = !ej_empty`; `ej_data_o` is the head. A pop occurs when `ej_valid_o && ej_ready_i`.
- **Ejection backpressure:** `rtr_off_o` is registered and equals `(next ejection occupancy >= EJ_DEPTH - OFF_SLACK)`.
- **FIFO implementation:** circular buffers with `log2(depth)+1`-bit pointers. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- **Reset:** on `rst`, both FIFOs empty, and `rtr_valid_o`, `rtr_data_o`, `rtr_off_o`, `ej_valid_o`, both counters, and `ovf_o` are 0.
  - `inj_ready_o` is 0 while `rst` is high and 1 in the first cycle after it falls.
  - Reset mid-transfer discards all buffered flits; no partial state survives.
- Self-addressed packets (dest equal to the own node) are injected normally; no internal loopback.

## Timing
- **Injection latency:** packet accepted at edge t with the FIFO previously empty and `rtr_off_i` low at t+1 → `rtr_valid_o` high in cycle t+2 (sampled by the router at edge t+2).
- **Injection throughput:** 1 flit/cycle sustained while `rtr_off_i` stays low.
- **Off response:** `rtr_off_i` high in cycle c → `rtr_valid_o` low in c+1.
- **Ejection latency:** flit written at edge t → `ej_valid_o` high in the cycle after edge t.
- **Ejection backpressure:** `rtr_off_o` updates at the same edge as the occupancy change that crosses the threshold.
- Counters update at the same edge as the corresponding transfer.

## Test plan
- **Reset state:** drive `rst` for 3 cycles with random inputs → all outputs 0 during reset; `inj_ready_o` 1 on the first cycle after reset.
- **Single packet:** inject dest=`{2'd3, 2'd1}`, payload=`4'hA` with `rtr_off_i = 0` → `rtr_data_o = 8'hDA`, `rtr_valid_o` high 2 cycles after acceptance for 1 cycle; `inj_cnt_o = 1`.
- **Injection backpressure:** inject 4 packets, then hold `rtr_off_i = 1` for 5 cycles → no `rtr_valid_o` during the hold; `inj_ready_o` 0 once 4 entries are buffered; after release, 4 flits in order on consecutive cycles.
- **Ejection threshold:** `EJ_DEPTH = 8`, `ej_ready_i = 0`, push 6 flits → `rtr_off_o` rises at the edge storing the 6th flit; 2 more pushes accepted; a 9th push sets `ovf_o` and `ej_cnt_o = 8`.
- **Simultaneous push and pop:** FIFO full, `ej_ready_i = 1` and `rtr_valid_i = 1` in the same cycle → both happen, occupancy stays 8, `ovf_o` remains 0, order preserved.
- **Wrap-around:** stream 100 flits through each direction with random `ej_ready_i` and `rtr_off_i` → data sequence intact, counters read 100.
